// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-128 encryption sequencer:
// round count, controller states, byte helpers, S-box and GF(2^8) doubling.
package aes_pkg;

  localparam int NR    = 10;
  localparam int RND_W = 4;
  localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(NR);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_DONE
  } ctrl_state_e;

  // Entry for input byte b sits at bits [2047-8*b -: 8].
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i (i = 4*col + row) occupies bits [127-8*i -: 8] of a block.
  function automatic int byte_msb(input int i);
    return 127 - 8*i;
  endfunction

  function automatic logic [7:0] get_byte(input logic [127:0] s, input int i);
    return s[byte_msb(i) -: 8];
  endfunction

endpackage

// File: rtl/aes_round_fn.sv
// Purely combinational AES round: SubBytes, ShiftRows, optional MixColumns
// (skipped on the final round) and the round-key XOR.
module aes_round_fn
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  input  logic         final_i,
  output logic [127:0] state_o
);

  logic [7:0] sr_bytes [16];
  logic [7:0] mc_bytes [16];

  function automatic logic [31:0] mix_col(input logic [7:0] a0, input logic [7:0] a1,
                                          input logic [7:0] a2, input logic [7:0] a3);
    logic [7:0] b0, b1, b2, b3;
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  // Row r of output column c takes the substituted byte from column (c+r) mod 4.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_bytes[4*c + r] = sbox(get_byte(state_i, 4*((c + r) % 4) + r));
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      {mc_bytes[4*c], mc_bytes[4*c + 1], mc_bytes[4*c + 2], mc_bytes[4*c + 3]} =
        mix_col(sr_bytes[4*c], sr_bytes[4*c + 1], sr_bytes[4*c + 2], sr_bytes[4*c + 3]);
    end
  end

  always_comb begin
    state_o = '0;
    for (int i = 0; i < 16; i++) begin
      state_o[byte_msb(i) -: 8] = (final_i ? sr_bytes[i] : mc_bytes[i]) ^ get_byte(key_i, i);
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 sequencer: initial AddRoundKey on acceptance, then NR
// passes through one shared round datapath, indexing one round key per cycle.
module aes_round_ctrl
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_data,
  output logic [RND_W-1:0]   rk_idx,
  input  logic [127:0]       rk_data,
  input  logic               clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_data,
  output logic               busy,
  output logic [RND_W-1:0]   round
);

  ctrl_state_e       fsm_q, fsm_d;
  logic [127:0]      state_q, state_d;
  logic [RND_W-1:0]  round_q, round_d;
  logic [127:0]      round_out;
  logic              final_round;

  assign final_round = (round_q == LAST_ROUND);

  aes_round_fn u_round_fn (
    .state_i (state_q),
    .key_i   (rk_data),
    .final_i (final_round),
    .state_o (round_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // clear outranks every transition and mirrors the reset values.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    if (clear) begin
      fsm_d   = ST_IDLE;
      state_d = '0;
      round_d = '0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_d = in_data ^ rk_data;
            round_d = RND_W'(1);
            fsm_d   = ST_ROUND;
          end
        end
        ST_ROUND: begin
          state_d = round_out;
          if (round_q < LAST_ROUND) begin
            round_d = round_q + RND_W'(1);
          end else begin
            fsm_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            round_d = '0;
            fsm_d   = ST_IDLE;
          end
        end
        default: fsm_d = ST_IDLE;
      endcase
    end
  end

  // in_ready is gated by rst so it reads low for the whole reset assertion.
  assign in_ready  = (fsm_q == ST_IDLE) && !rst;
  assign rk_idx    = (fsm_q == ST_ROUND) ? round_q : '0;
  assign out_valid = (fsm_q == ST_DONE);
  assign out_data  = state_q;
  assign busy      = (fsm_q != ST_IDLE);
  assign round     = round_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: FIPS-197 vectors from a table, plus
// backpressure, back-to-back, clear and asynchronous reset sequences.
module tb_aes_round_ctrl;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         clear;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic [3:0]   round;

  logic         key_sel;
  logic [127:0] rk_tab  [0:1][0:15];
  logic [127:0] key_tab [0:1];

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_R1   = 128'ha49c7ff2689f352b6b5bea43026a5049;

  typedef struct {
    string        name;
    logic [127:0] pt;
    logic         sel;
    logic [127:0] ct;
    logic         chk_r1;
    logic [127:0] r1;
  } vec_t;

  vec_t vecs [3];

  always #5 clk = ~clk;

  // External key-schedule store: combinational lookup by rk_idx.
  assign rk_data = rk_tab[key_sel][rk_idx];

  aes_round_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .round     (round)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expand_key(input int sel, input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= 10) rk_tab[sel][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else         rk_tab[sel][r] = '0;
    end
    key_tab[sel] = key;
  endtask

  task automatic run_block(input vec_t v);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      step();
      n++;
    end
    check({v.name, " ready"}, 128'(in_ready), 128'(1));
    key_sel   = v.sel;
    in_data   = v.pt;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check({v.name, " busy"}, 128'(busy), 128'(1));
    check({v.name, " ark"}, out_data, v.pt ^ key_tab[v.sel]);
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("%s rk_idx[%0d]", v.name, k), 128'(rk_idx), 128'(k));
      check($sformatf("%s early_valid[%0d]", v.name, k), 128'(out_valid), 128'(0));
      step();
      if (k == 1 && v.chk_r1) check({v.name, " round1"}, out_data, v.r1);
    end
    check({v.name, " out_valid"}, 128'(out_valid), 128'(1));
    check({v.name, " ct"}, out_data, v.ct);
    step();
    check({v.name, " post_valid"}, 128'(out_valid), 128'(0));
    check({v.name, " post_ready"}, 128'(in_ready), 128'(1));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int seen;
    int outs;
    logic saw_valid;

    rst       = 1'b1;
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    key_sel   = 1'b0;
    expand_key(0, C1_KEY);
    expand_key(1, B_KEY);
    vecs[0] = '{name: "c1",   pt: C1_PT, sel: 1'b0, ct: C1_CT, chk_r1: 1'b0, r1: '0};
    vecs[1] = '{name: "b",    pt: B_PT,  sel: 1'b1, ct: B_CT,  chk_r1: 1'b1, r1: B_R1};
    vecs[2] = '{name: "c1_2", pt: C1_PT, sel: 1'b0, ct: C1_CT, chk_r1: 1'b0, r1: '0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", 128'(in_ready), 128'(0));
    check("rst out_valid", 128'(out_valid), 128'(0));
    check("rst busy", 128'(busy), 128'(0));
    check("rst rk_idx", 128'(rk_idx), 128'(0));
    check("rst round", 128'(round), 128'(0));
    check("rst out_data", out_data, 128'(0));
    #3 rst = 1'b0;
    #1;
    check("post_rst in_ready", 128'(in_ready), 128'(1));

    for (int i = 0; i < 3; i++) run_block(vecs[i]);

    // Backpressure in DONE
    key_sel   = 1'b1;
    in_data   = B_PT;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 15) begin
      step();
      n++;
    end
    check("bp reach_done", 128'(out_valid), 128'(1));
    for (int k = 0; k < 5; k++) begin
      in_valid = (k % 2 == 0);
      in_data  = C1_PT;
      check($sformatf("bp valid[%0d]", k), 128'(out_valid), 128'(1));
      check($sformatf("bp data[%0d]", k), out_data, B_CT);
      check($sformatf("bp in_ready[%0d]", k), 128'(in_ready), 128'(0));
      step();
    end
    in_valid = 1'b0;
    check("bp still_valid", 128'(out_valid), 128'(1));
    check("bp still_data", out_data, B_CT);
    out_ready = 1'b1;
    step();
    check("bp hs out_valid", 128'(out_valid), 128'(0));
    check("bp hs in_ready", 128'(in_ready), 128'(1));
    check("bp hs round", 128'(round), 128'(0));
    check("bp hs busy", 128'(busy), 128'(0));

    // Back-to-back with in_valid held high
    key_sel  = 1'b0;
    in_data  = C1_PT;
    in_valid = 1'b1;
    step();
    seen = -1;
    outs = 0;
    for (int e = 1; e <= 24; e++) begin
      step();
      if (seen >= 0 && e == seen + 1) in_valid = 1'b0;
      if (out_valid) begin
        outs++;
        check($sformatf("b2b ct[%0d]", outs), out_data, C1_CT);
      end
      if (in_ready && seen < 0) seen = e;
    end
    in_valid = 1'b0;
    check("b2b gap", 128'(seen + 1), 128'(12));
    check("b2b outs", 128'(outs), 128'(2));

    // Clear at round 5
    n = 0;
    while (!in_ready && n < 30) begin
      step();
      n++;
    end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    check("clr at_round5", 128'(round), 128'(5));
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr round", 128'(round), 128'(0));
    check("clr busy", 128'(busy), 128'(0));
    check("clr in_ready", 128'(in_ready), 128'(1));
    check("clr out_data", out_data, 128'(0));
    saw_valid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (out_valid) saw_valid = 1'b1;
      step();
    end
    check("clr no_valid", 128'(saw_valid), 128'(0));

    // Clear coincident with an IDLE handshake drops the block
    in_valid = 1'b1;
    clear    = 1'b1;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_hs busy", 128'(busy), 128'(0));
    check("clr_hs round", 128'(round), 128'(0));
    step();
    check("clr_hs still_idle", 128'(busy), 128'(0));

    // Asynchronous reset mid-block
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    check("arst at_round3", 128'(round), 128'(3));
    #3 rst = 1'b1;
    #1;
    check("arst out_data", out_data, 128'(0));
    check("arst round", 128'(round), 128'(0));
    check("arst busy", 128'(busy), 128'(0));
    check("arst in_ready", 128'(in_ready), 128'(0));
    check("arst rk_idx", 128'(rk_idx), 128'(0));
    check("arst out_valid", 128'(out_valid), 128'(0));
    #2 rst = 1'b0;
    run_block(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Iterative AES-128 encryption sequencer. Accepts one 128-bit plaintext block per transaction, runs the initial AddRoundKey, nine full rounds and the final round through a single shared round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey), and presents the ciphertext. Sits between the host-side block interface and the external key-schedule store, which it indexes one round key per cycle.

Parameters:
NR, 10, number of rounds (AES-128); the round counter is 4 bits wide.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  plaintext block valid
in_ready  output  1  controller can accept a block
in_data  input  128  plaintext; bits 127:120 = byte 0 (s0,0), column-major order
rk_idx  output  4  round-key index requested this cycle (0..NR)
rk_data  input  128  round key for rk_idx, combinational, same cycle
clear  input  1  synchronous abort, returns to IDLE
out_valid  output  1  ciphertext valid
out_ready  input  1  consumer accepts ciphertext
out_data  output  128  ciphertext, same byte order as in_data
busy  output  1  high in ROUND and DONE
round  output  4  current round counter (debug)

Behaviour:
- Reset (asynchronous, rst=1): FSM=IDLE, state register=0, round=0, out_valid=0, in_ready=0 while rst is asserted, busy=0, rk_idx=0. in_ready=1 from the first IDLE cycle after rst deasserts.
- FSM states: IDLE, ROUND, DONE.
- IDLE: in_ready=1, rk_idx=0. On in_valid&&in_ready: state <= in_data ^ rk_data; round <= 1; go to ROUND.
- ROUND: in_ready=0, rk_idx=round. Each cycle: state <= round_fn(state, rk_data, final), where final=(round==NR); round_fn omits MixColumns when final=1. If round<NR then round <= round+1; otherwise go to DONE.
- DONE: out_valid=1, out_data=state, held stable until out_ready. On out_ready: out_valid <= 0, round <= 0, go to IDLE. No new block is accepted in the cycle where out_ready is seen; in_ready rises on the following cycle.
- Latency: acceptance at edge T sets out_valid=1 after edge T+NR (10 ROUND cycles). Throughput is one block per NR+2 cycles with out_ready tied high.
- out_data equals the state register in all states. It is qualified only by out_valid.
- clear: has priority over every other transition. In any state it forces the same values as reset on the next edge. A clear in the same cycle as an IDLE handshake drops that block.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- Round counter: never exceeds NR and never wraps. rk_idx is always in 0..NR.
- ShiftRows: row r rotates left by r bytes. Byte index i = 4*col + row.

Decomposition:
- Shared package aes_pkg holds:
  - NR and the round-counter width.
  - FSM state enum (IDLE, ROUND, DONE).
  - Byte-indexing helpers.
  - S-box table constant.
  - xtime function.
- Sub-module aes_round_fn: a purely combinational round.
  - Inputs: state, round key, final flag.
  - Output: next state.
  - Implements SubBytes (16 S-box lookups), ShiftRows, conditional MixColumns and the key XOR.
  - aes_round_ctrl holds all sequential logic.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f supplied by the bench key-schedule model, in_data=00112233445566778899aabbccddeeff, out_ready=1 -> out_valid exactly 10 cycles after acceptance, out_data=69c4e0d86a7b0430d8cdb78070b4c55a; rk_idx steps through 0,1,...,10.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, in_data=3243f6a8885a308d313198a2e0370734 -> out_data=3925841d02dc09fbdc118597196a0b32. Check the state after round 1 equals a49c7ff2689f352b6b5bea43026a5049.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0, in_valid pulses ignored. Release -> one-cycle handshake, then IDLE.
- Back-to-back: two blocks with in_valid held high and out_ready=1 -> second acceptance 12 cycles after the first; both ciphertexts correct.
- Abort/reset: assert clear at round 5 -> next cycle IDLE, round=0, out_valid never pulses. Repeat with an asynchronous rst pulse mid-edge -> outputs zero immediately; a subsequent C.1 vector still passes.
